// File: rtl/s32x_fb_draw_arbiter_pkg.sv
// Shared types and timing constants for the 32X frame-buffer draw-side arbiter.
// Also holds the byte-lane write-enable rule for queued CPU writes.
package s32x_fb_draw_arbiter_pkg;

   localparam int WR_CYC   = 6;
   localparam int RD_CYC   = 7;
   localparam int FILL_CYC = 3;
   localparam int RFRH_LEN = 40;
   localparam int CNT_W    = 6;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RFRH,
      ST_FILL,
      ST_WRITE,
      ST_READ
   } FBArbState_t;

   typedef struct packed {
      logic [15:0] a;
      logic [15:0] d;
      logic [7:0]  len;
   } FillCtx_t;

   // Overwrite-image writes treat a zero byte as transparent; normal writes
   // only drop a lane when it is the sole enabled lane and its byte is zero.
   function automatic logic [1:0] wr_lane_en(input logic ovr, input logic [1:0] be,
                                              input logic [15:0] d);
      logic hi_nz;
      logic lo_nz;
      hi_nz = |d[15:8];
      lo_nz = |d[7:0];
      if (ovr)
         return {be[1] & hi_nz, be[0] & lo_nz};
      else
         return {be[1] & (hi_nz | be[0]), be[0] & (lo_nz | be[1])};
   endfunction

endpackage

// File: rtl/s32x_fb_draw_arbiter.sv
// Non-preemptive fixed-priority sequencer for refresh, auto-fill, queued CPU writes
// and CPU reads on one frame-buffer DRAM port.
import s32x_fb_draw_arbiter_pkg::*;

module s32x_fb_draw_arbiter (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        CE_R,
   input  logic        RFRH_START,
   input  logic        FILL_START,
   input  logic [15:0] FILL_A,
   input  logic [15:0] FILL_D,
   input  logic [7:0]  FILL_LEN,
   output logic [15:0] FILL_A_CUR,
   input  logic        WR_VALID,
   input  logic [16:0] WR_A,
   input  logic [1:0]  WR_BE,
   input  logic [15:0] WR_D,
   output logic        WR_POP,
   input  logic        RD_REQ,
   input  logic [15:0] RD_A,
   output logic        RD_ACK,
   output logic [15:0] RD_Q,
   output logic [15:0] MEM_A,
   output logic [15:0] MEM_D,
   output logic [1:0]  MEM_WE,
   output logic        MEM_RD,
   input  logic [15:0] MEM_Q,
   output logic        FEN,
   output logic        WR_BUSY
);

   FBArbState_t      state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic [1:0]       phase_reg, phase_next;
   FillCtx_t         fill_reg, fill_next;
   logic             rfrh_pend_reg, rfrh_pend_next;
   logic             fill_pend_reg, fill_pend_next;
   logic [15:0]      wr_a_reg, wr_a_next;
   logic [15:0]      wr_d_reg, wr_d_next;
   logic [1:0]       wr_we_reg, wr_we_next;
   logic [15:0]      rd_a_reg, rd_a_next;
   logic [15:0]      rd_q_reg, rd_q_next;
   logic             rd_ack_reg, rd_ack_next;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_reg     <= ST_IDLE;
         cnt_reg       <= '0;
         phase_reg     <= '0;
         fill_reg      <= '0;
         rfrh_pend_reg <= 1'b0;
         fill_pend_reg <= 1'b0;
         wr_a_reg      <= '0;
         wr_d_reg      <= '0;
         wr_we_reg     <= '0;
         rd_a_reg      <= '0;
         rd_q_reg      <= '0;
         rd_ack_reg    <= 1'b0;
      end else begin
         state_reg     <= state_next;
         cnt_reg       <= cnt_next;
         phase_reg     <= phase_next;
         fill_reg      <= fill_next;
         rfrh_pend_reg <= rfrh_pend_next;
         fill_pend_reg <= fill_pend_next;
         wr_a_reg      <= wr_a_next;
         wr_d_reg      <= wr_d_next;
         wr_we_reg     <= wr_we_next;
         rd_a_reg      <= rd_a_next;
         rd_q_reg      <= rd_q_next;
         rd_ack_reg    <= rd_ack_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      cnt_next       = cnt_reg;
      phase_next     = phase_reg;
      fill_next      = fill_reg;
      rfrh_pend_next = rfrh_pend_reg | RFRH_START;
      // A fill restart while filling is applied directly, not queued.
      fill_pend_next = fill_pend_reg | (FILL_START & (state_reg != ST_FILL));
      wr_a_next      = wr_a_reg;
      wr_d_next      = wr_d_reg;
      wr_we_next     = wr_we_reg;
      rd_a_next      = rd_a_reg;
      rd_q_next      = rd_q_reg;
      rd_ack_next    = 1'b0;
      WR_POP         = 1'b0;
      MEM_A          = RD_A;
      MEM_D          = '0;
      MEM_WE         = '0;
      MEM_RD         = 1'b0;

      case (state_reg)
         ST_IDLE: begin
            if (rfrh_pend_reg) begin
               state_next     = ST_RFRH;
               cnt_next       = CNT_W'(RFRH_LEN - 1);
               rfrh_pend_next = RFRH_START;
            end else if (fill_pend_reg) begin
               state_next     = ST_FILL;
               fill_next      = '{a: FILL_A, d: FILL_D, len: FILL_LEN};
               phase_next     = '0;
               fill_pend_next = 1'b0;
            end else if (WR_VALID) begin
               state_next = ST_WRITE;
               cnt_next   = CNT_W'(WR_CYC - 1);
               WR_POP     = 1'b1;
               wr_a_next  = WR_A[15:0];
               wr_d_next  = WR_D;
               wr_we_next = wr_lane_en(WR_A[16], WR_BE, WR_D);
            end else if (RD_REQ && !rd_ack_reg) begin
               // The ack cycle is skipped so a held request is not re-issued.
               state_next = ST_READ;
               cnt_next   = CNT_W'(RD_CYC - 1);
               rd_a_next  = RD_A;
            end
         end
         ST_RFRH: begin
            MEM_A = '0;
            if (CE_R) begin
               if (cnt_reg == '0)
                  state_next = ST_IDLE;
               else
                  cnt_next = cnt_reg - 1'b1;
            end
         end
         ST_FILL: begin
            MEM_A  = fill_reg.a;
            MEM_D  = fill_reg.d;
            MEM_WE = (phase_reg == '0) ? 2'b11 : 2'b00;
            if (FILL_START) begin
               fill_next  = '{a: FILL_A, d: FILL_D, len: FILL_LEN};
               phase_next = '0;
            end else if (CE_R) begin
               if (phase_reg == 2'(FILL_CYC - 1)) begin
                  phase_next = '0;
                  if (fill_reg.len == '0) begin
                     state_next = ST_IDLE;
                  end else begin
                     fill_next.a[7:0] = fill_reg.a[7:0] + 8'd1;
                     fill_next.len    = fill_reg.len - 8'd1;
                  end
               end else begin
                  phase_next = phase_reg + 2'd1;
               end
            end
         end
         ST_WRITE: begin
            MEM_A  = wr_a_reg;
            MEM_D  = wr_d_reg;
            MEM_WE = wr_we_reg;
            if (cnt_reg == '0)
               state_next = ST_IDLE;
            else
               cnt_next = cnt_reg - 1'b1;
         end
         ST_READ: begin
            MEM_A  = rd_a_reg;
            MEM_RD = 1'b1;
            if (cnt_reg == '0) begin
               state_next  = ST_IDLE;
               rd_q_next   = MEM_Q;
               rd_ack_next = 1'b1;
            end else begin
               cnt_next = cnt_reg - 1'b1;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   assign FILL_A_CUR = fill_reg.a;
   assign RD_ACK     = rd_ack_reg;
   assign RD_Q       = rd_q_reg;
   assign WR_BUSY    = (state_reg == ST_WRITE) | WR_VALID;
   assign FEN        = RFRH_START | FILL_START | rfrh_pend_reg | fill_pend_reg |
                       (state_reg == ST_RFRH) | (state_reg == ST_FILL);

endmodule
